ivl_uvm_rr_arb: RTL and testbench

//  Round-robin arbiter producing the one-hot-or-zero grant vector (arb_gnt_vec) consumed by the
//  OVL grant checks in the test benches. N requesters compete for one shared resource; the owner

---
 rtl/ivl_uvm_rr_arb.sv | 132 +++++++++++++
 tb/tb_ivl_uvm_rr_arb.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ivl_uvm_rr_arb.sv
// Round-robin arbiter with a registered one-hot-or-zero grant and an idle gap between owners.
// Optional hold timeout is built when IVL_UVM_RR_ARB_TIMEOUT_EN is defined.
module ivl_uvm_rr_arb #(
    parameter int N_REQ = 8,
    parameter int MAX_HOLD = 16,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] arb_gnt_vec,
    output logic             gnt_valid,
    output logic [IW-1:0]    gnt_id,
    output logic             timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0] gnt_vec_d;
    logic [IW-1:0]    gnt_id_d;
    logic             gnt_valid_d;
    logic             timeout_pulse_d;
    logic             timeout_hit;

    logic [IW-1:0]    scan_idx;
    logic [IW-1:0]    win_id;
    logic             win_found;
    logic [IW-1:0]    win_next;

    if (N_REQ < 2 || N_REQ > 32 || MAX_HOLD < 2) begin : g_bad_cfg
        $error("ivl_uvm_rr_arb: N_REQ must be 2..32 and MAX_HOLD >= 2");
    end

    // First requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = IW'((int'(rr_ptr_q) + k) % N_REQ);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
        win_next = (win_id == IW'(N_REQ - 1)) ? '0 : win_id + 1'b1;
    end

`ifdef IVL_UVM_RR_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state_d == GRANT && state_q != GRANT) begin
            hold_cnt <= '0;
        end else if (state_q == GRANT && hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state_q == GRANT) && (hold_cnt == HOLD_MAX) && !done;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        gnt_vec_d       = arb_gnt_vec;
        gnt_id_d        = gnt_id;
        timeout_pulse_d = 1'b0;
        unique case (state_q)
            IDLE, RELEASE: begin
                if (win_found) begin
                    state_d           = GRANT;
                    gnt_vec_d         = '0;
                    gnt_vec_d[win_id] = 1'b1;
                    gnt_id_d          = win_id;
                    rr_ptr_d          = win_next;
                end else begin
                    state_d   = IDLE;
                    gnt_vec_d = '0;
                    gnt_id_d  = '0;
                end
            end
            GRANT: begin
                if (done || !req[gnt_id] || timeout_hit) begin
                    state_d         = RELEASE;
                    gnt_vec_d       = '0;
                    gnt_id_d        = '0;
                    timeout_pulse_d = timeout_hit;
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_vec_d = '0;
                gnt_id_d  = '0;
            end
        endcase
        gnt_valid_d = |gnt_vec_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            arb_gnt_vec   <= '0;
            gnt_valid     <= 1'b0;
            gnt_id        <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            arb_gnt_vec   <= gnt_vec_d;
            gnt_valid     <= gnt_valid_d;
            gnt_id        <= gnt_id_d;
            timeout_pulse <= timeout_pulse_d;
        end
    end

endmodule

// File: tb/tb_ivl_uvm_rr_arb.sv
// Scoreboard bench for ivl_uvm_rr_arb: driver pushes model predictions, monitor pops and compares.
module tb_ivl_uvm_rr_arb;

    localparam int N  = 4;
    localparam int MH = 8;
`ifdef IVL_UVM_RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic         done = 1'b0;
    logic [N-1:0] arb_gnt_vec;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         timeout_pulse;

    always #5 clk = ~clk;

    ivl_uvm_rr_arb #(
        .N_REQ(N),
        .MAX_HOLD(MH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .done(done),
        .arb_gnt_vec(arb_gnt_vec),
        .gnt_valid(gnt_valid),
        .gnt_id(gnt_id),
        .timeout_pulse(timeout_pulse)
    );

    typedef struct packed {
        logic [N-1:0] vec;
        logic [1:0]   id;
        logic         v;
        logic         tp;
    } exp_t;

    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;

    // Reference: who owns the resource, where priority starts, how long held.
    int owner = -1;
    int ptr = 0;
    int held = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        owner = -1;
        ptr   = 0;
        held  = 0;
    endfunction

    function automatic exp_t model_step(input logic [N-1:0] r, input logic d);
        exp_t e;
        bit to;
        to = 1'b0;
        if (owner >= 0) begin
            to = TO_EN && (held == MH - 1) && !d;
            if (d || !r[owner] || to) owner = -1;
            else if (held < MH - 1) held++;
        end else if (r != 0) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (ptr + k) % N;
                if (r[i]) begin
                    owner = i;
                    break;
                end
            end
            ptr  = (owner + 1) % N;
            held = 0;
        end
        e.vec = (owner >= 0) ? N'(1 << owner) : '0;
        e.id  = (owner >= 0) ? 2'(owner) : 2'd0;
        e.v   = (owner >= 0);
        e.tp  = to;
        return e;
    endfunction

    task automatic step(input logic [N-1:0] r, input logic d);
        @(negedge clk);
        req  = r;
        done = d;
        exp_q.push_back(model_step(r, d));
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("gnt_vec", 32'(arb_gnt_vec), 32'(e.vec));
            chk("gnt_id", 32'(gnt_id), 32'(e.id));
            chk("gnt_valid", 32'(gnt_valid), 32'(e.v));
            chk("timeout_pulse", 32'(timeout_pulse), 32'(e.tp));
        end
        chk("onehot", 32'($countones(arb_gnt_vec) <= 1), 32'd1);
    end

    initial begin
        logic [N-1:0] r;
        logic         d;

        rst_n = 1'b0;
        req   = 4'b1111;
        repeat (5) begin
            @(negedge clk);
            chk("rst_vec", 32'(arb_gnt_vec), 32'd0);
            chk("rst_valid", 32'(gnt_valid), 32'd0);
            chk("rst_id", 32'(gnt_id), 32'd0);
        end
        req   = '0;
        rst_n = 1'b1;
        model_reset();

        step(4'b0100, 1'b0);
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b1);
        step(4'b0000, 1'b0);

        step(4'b1111, 1'b0);
        repeat (10) step(4'b1111, owner >= 0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        step(4'b0100, 1'b0);
        step(4'b0100, 1'b1);
        step(4'b0011, 1'b0);
        step(4'b0011, 1'b1);
        step(4'b0011, 1'b0);
        step(4'b0011, 1'b1);
        step(4'b0000, 1'b0);

        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vec", 32'(arb_gnt_vec), 32'd0);
        chk("mid_rst_valid", 32'(gnt_valid), 32'd0);
        chk("mid_rst_id", 32'(gnt_id), 32'd0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;
        step(4'b1010, 1'b0);
        step(4'b1010, 1'b1);
        step(4'b1010, 1'b0);
        step(4'b0000, 1'b0);

        repeat (24) step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        r = '0;
        repeat (1500) begin
            if ($urandom_range(0, 2) == 0) r = N'($urandom_range(0, 15));
            d = ($urandom_range(0, 3) == 0);
            step(r, d);
        end
        step(4'b0000, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
